// File: rtl/add_chk_pkg.sv
// Shared types and constants for the adder response checker.
// Holds the checker FSM state encoding and the default sizing constants.
package add_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_CNT_W = 8;
    // Deepest response latency the checker is built to align against.
    localparam int LAT_MAX   = 4;
    // Width of the drain cycle counter, enough to count up to LAT_MAX.
    localparam int DRAIN_W   = $clog2(LAT_MAX + 1);

endpackage

// File: rtl/add_chk_dly.sv
// Alignment delay line for the adder response checker.
// Carries {valid, expected} through LAT register stages so the golden value
// reaches the comparator in the same cycle as the DUT's delayed response.
// With LAT=0 the line is a wire (the compare is purely combinational).
// flush_i drops every in-flight valid bit so a new run starts empty.
module add_chk_dly #(
    parameter int DW  = 4,
    parameter int LAT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    genvar gi;

    if (LAT == 0) begin : g_bypass
        // No stages to clock or reset in the zero-latency build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk | rst;
        assign valid_o        = valid_i & ~flush_i;
        assign data_o         = data_i;
    end else begin : g_pipe
        logic          vld_chain [LAT+1];
        logic [DW-1:0] exp_chain [LAT+1];

        assign vld_chain[0] = valid_i;
        assign exp_chain[0] = data_i;

        for (gi = 0; gi < LAT; gi++) begin : g_stage
            logic          vld_q;
            logic [DW-1:0] exp_q;

            // One pipeline stage; valid is cleared on flush so stale
            // expectations never reach the comparator in a new run.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    exp_q <= '0;
                end else begin
                    vld_q <= vld_chain[gi] & ~flush_i;
                    exp_q <= exp_chain[gi];
                end
            end

            assign vld_chain[gi+1] = vld_q;
            assign exp_chain[gi+1] = exp_q;
        end

        assign valid_o = vld_chain[LAT];
        assign data_o  = exp_chain[LAT];
    end

endmodule

// File: rtl/add_resp_checker.sv
// Response-side checker for the WIDTH-bit ripple adder.
// Computes the golden {carry, sum} of each accepted vector, aligns it with
// the DUT response LAT cycles later, and counts compares and mismatches.
// After NUM_VECTORS accepts (plus LAT drain cycles) it reports a verdict.
// Optional capture of the first failing vector index is enabled by defining
// the macro CHK_FIRST_ERR_EN; otherwise first_err_idx/first_err_vld are 0.
module add_resp_checker
    import add_chk_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_VECTORS = 16,
    parameter int LAT         = 0,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic             vec_ci,
    input  logic [WIDTH-1:0] dut_s,
    input  logic             dut_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
);

    localparam int                  EXP_W      = WIDTH + 1;
    localparam int                  ACC_W      = $clog2(NUM_VECTORS + 1);
    localparam logic [ACC_W-1:0]    ACC_NUM    = ACC_W'(NUM_VECTORS);
    localparam logic [ACC_W-1:0]    ACC_LAST   = ACC_W'(NUM_VECTORS - 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'((LAT > 0) ? LAT - 1 : 0);
    localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};

    chk_state_e         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               start_ok;
    logic               accept;
    logic               last_accept;
    logic [EXP_W-1:0]   exp_in;
    logic [EXP_W-1:0]   exp_cmp;
    logic               cmp_valid;
    logic               mismatch;

    // A run may only be (re)started from a quiescent state.
    assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
    // The accept count is independent of vec_cnt so the drain length is exact.
    assign accept      = vec_valid && (state_q == RUN) && (acc_q < ACC_NUM);
    assign last_accept = accept && (acc_q == ACC_LAST);

    // Golden sum at full WIDTH+1 precision; the top bit is the carry.
    assign exp_in = EXP_W'(vec_a) + EXP_W'(vec_b) + EXP_W'(vec_ci);

    add_chk_dly #(
        .DW  (EXP_W),
        .LAT (LAT)
    ) u_dly (
        .clk     (clk),
        .rst     (rst),
        .flush_i (start_ok),
        .valid_i (accept),
        .data_i  (exp_in),
        .valid_o (cmp_valid),
        .data_o  (exp_cmp)
    );

    assign mismatch = cmp_valid && ({dut_c, dut_s} != exp_cmp);

    // Next-state logic: run sequencing, accept counting and drain timing.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    acc_d   = '0;
                    drain_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_d = acc_q + 1'b1;
                end
                if (last_accept) begin
                    drain_d = '0;
                    state_d = (LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and run bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            drain_q <= drain_d;
        end
    end

    // Compare bookkeeping: every retired compare counts, mismatches saturate.
    always_comb begin
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        if (cmp_valid) begin
            vec_cnt_d = vec_cnt_q + 1'b1;
            if (mismatch && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
        if (start_ok) begin
            vec_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef CHK_FIRST_ERR_EN
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic             first_vld_q, first_vld_d;

    // Latch the index of the first mismatch only; later ones are ignored.
    always_comb begin
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;
        if (mismatch && !first_vld_q) begin
            first_idx_d = vec_cnt_q;
            first_vld_d = 1'b1;
        end
        if (start_ok) begin
            first_idx_d = '0;
            first_vld_d = 1'b0;
        end
    end

    // First-error capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
        end else begin
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
        end
    end

    assign first_err_idx = first_idx_q;
    assign first_err_vld = first_vld_q;
`else
    assign first_err_idx = '0;
    assign first_err_vld = 1'b0;
`endif

    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign pass    = done && (err_cnt_q == '0);
    assign vec_cnt = vec_cnt_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_add_resp_checker.sv
// Bench for add_resp_checker: three instances share one stimulus stream.
//   u0: LAT=0, CNT_W=8, response = golden ^ fault mask (combinational)
//   u2: LAT=2, CNT_W=8, same response delayed two clocks
//   u3: LAT=0, CNT_W=2, sum optionally stuck at 0 (saturation)
module tb_add_resp_checker;

    localparam int N = 16;

`ifdef CHK_FIRST_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       start     = 1'b0;
    logic       vec_valid = 1'b0;
    logic       vec_ci    = 1'b0;
    logic [2:0] vec_a     = '0;
    logic [2:0] vec_b     = '0;
    logic [3:0] fmask     = '0;
    logic       stuck     = 1'b0;

    always #5 clk = ~clk;

    // Stand-in adder DUTs.
    logic [3:0] gold, resp0;
    logic [3:0] r1 = '0;
    logic [3:0] r2 = '0;
    assign gold  = {1'b0, vec_a} + {1'b0, vec_b} + {3'b000, vec_ci};
    assign resp0 = gold ^ fmask;
    always @(posedge clk) begin
        r1 <= resp0;
        r2 <= r1;
    end

    logic       busy0, done0, pass0, fv0;
    logic [7:0] vc0, ec0, fi0;
    logic       busy2, done2, pass2, fv2;
    logic [7:0] vc2, ec2, fi2;
    logic       busy3, done3, pass3, fv3;
    logic [1:0] vc3, ec3, fi3;

    add_resp_checker #(.WIDTH(3), .NUM_VECTORS(N), .LAT(0), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_a(vec_a), .vec_b(vec_b), .vec_ci(vec_ci),
        .dut_s(resp0[2:0]), .dut_c(resp0[3]),
        .busy(busy0), .done(done0), .pass(pass0), .vec_cnt(vc0), .err_cnt(ec0),
        .first_err_idx(fi0), .first_err_vld(fv0));

    add_resp_checker #(.WIDTH(3), .NUM_VECTORS(N), .LAT(2), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_a(vec_a), .vec_b(vec_b), .vec_ci(vec_ci),
        .dut_s(r2[2:0]), .dut_c(r2[3]),
        .busy(busy2), .done(done2), .pass(pass2), .vec_cnt(vc2), .err_cnt(ec2),
        .first_err_idx(fi2), .first_err_vld(fv2));

    add_resp_checker #(.WIDTH(3), .NUM_VECTORS(N), .LAT(0), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid),
        .vec_a(vec_a), .vec_b(vec_b), .vec_ci(vec_ci),
        .dut_s(stuck ? 3'b000 : gold[2:0]), .dut_c(gold[3]),
        .busy(busy3), .done(done3), .pass(pass3), .vec_cnt(vc3), .err_cnt(ec3),
        .first_err_idx(fi3), .first_err_vld(fv3));

    // Directed vector table: a=b=i%8, ci=i/8, optional carry fault at index 7.
    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       ci;
        logic [3:0] fmask;
        int         exp_err;
    } vec_rec_t;
    vec_rec_t tbl [N];

    int n_applied = 0;
    int n_checks  = 0;
    int n_mis     = 0;

    // Reference model: run-level bookkeeping.
    bit m_active = 1'b0;
    int m_acc    = 0;
    int m_err0   = 0;
    int m_err3   = 0;
    int m_first0 = -1;
    int m_first3 = -1;

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", nm, act, expv);
        end
    endtask

    task automatic model_clear();
        m_acc    = 0;
        m_err0   = 0;
        m_err3   = 0;
        m_first0 = -1;
        m_first3 = -1;
    endtask

    // Drive one cycle of stimulus, update the model, advance to next negedge.
    task automatic put(input logic [2:0] va, input logic [2:0] vb, input logic vci,
                       input logic [3:0] vm, input logic vv, input logic vs);
        int  sum;
        bit  was_active;
        was_active = m_active;
        start      = vs;
        vec_valid  = vv;
        vec_a      = va;
        vec_b      = vb;
        vec_ci     = vci;
        fmask      = vm;
        if (vv) n_applied++;
        if (vv && was_active && m_acc < N) begin
            sum = int'(va) + int'(vb) + int'(vci);
            if ((sum ^ int'(vm)) != sum) begin
                if (m_first0 < 0) m_first0 = m_acc;
                m_err0++;
            end
            if (stuck && (sum % 8) != 0) begin
                if (m_first3 < 0) m_first3 = m_acc;
                m_err3++;
            end
            m_acc++;
            if (m_acc == N) m_active = 1'b0;
        end
        if (vs && !was_active) begin
            m_active = 1'b1;
            model_clear();
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic vs);
        put(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'b0, vs);
    endtask

    // Called right after the last accepted vector: checks drain timing.
    task automatic finish_run(input string tag);
        chk({tag, " u0 done"}, done0, 1);
        chk({tag, " u0 busy"}, busy0, 0);
        chk({tag, " u2 drain1 busy"}, busy2, 1);
        chk({tag, " u2 drain1 done"}, done2, 0);
        idle(1'b0);
        chk({tag, " u2 drain2 busy"}, busy2, 1);
        chk({tag, " u2 drain2 done"}, done2, 0);
        idle(1'b0);
        chk({tag, " u2 done"}, done2, 1);
        chk({tag, " u2 busy"}, busy2, 0);
    endtask

    task automatic check_all(input string tag);
        int e0, e3;
        e0 = sat(m_err0, 255);
        e3 = sat(m_err3, 3);
        chk({tag, " u0 vec_cnt"}, vc0, m_acc % 256);
        chk({tag, " u0 err_cnt"}, ec0, e0);
        chk({tag, " u0 pass"}, pass0, (e0 == 0));
        chk({tag, " u0 first_vld"}, fv0, FE && (m_first0 >= 0));
        chk({tag, " u0 first_idx"}, fi0, (FE && m_first0 >= 0) ? m_first0 : 0);
        chk({tag, " u2 vec_cnt"}, vc2, m_acc % 256);
        chk({tag, " u2 err_cnt"}, ec2, e0);
        chk({tag, " u2 pass"}, pass2, (e0 == 0));
        chk({tag, " u2 first_vld"}, fv2, FE && (m_first0 >= 0));
        chk({tag, " u2 first_idx"}, fi2, (FE && m_first0 >= 0) ? m_first0 : 0);
        chk({tag, " u3 done"}, done3, 1);
        chk({tag, " u3 vec_cnt"}, vc3, m_acc % 4);
        chk({tag, " u3 err_cnt"}, ec3, e3);
        chk({tag, " u3 pass"}, pass3, (e3 == 0));
        chk({tag, " u3 first_vld"}, fv3, FE && (m_first3 >= 0));
        chk({tag, " u3 first_idx"}, fi3, (FE && m_first3 >= 0) ? (m_first3 % 4) : 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " u0 busy"}, busy0, 0);
        chk({tag, " u0 done"}, done0, 0);
        chk({tag, " u0 pass"}, pass0, 0);
        chk({tag, " u0 vec_cnt"}, vc0, 0);
        chk({tag, " u0 err_cnt"}, ec0, 0);
        chk({tag, " u0 first"}, {fv0, fi0}, 0);
        chk({tag, " u2 busy"}, busy2, 0);
        chk({tag, " u2 done"}, done2, 0);
        chk({tag, " u2 cnts"}, {vc2, ec2, fv2, fi2}, 0);
        chk({tag, " u3 state"}, {busy3, done3, pass3}, 0);
        chk({tag, " u3 cnts"}, {vc3, ec3, fv3, fi3}, 0);
    endtask

    task automatic dir_run(input string tag, input bit fault, input bit start_mid);
        put(3'd0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++) begin
            put(tbl[i].a, tbl[i].b, tbl[i].ci, fault ? tbl[i].fmask : 4'd0, 1'b1,
                start_mid && (i == 5));
            chk($sformatf("%s vec%0d vec_cnt", tag, i), vc0, i + 1);
            chk($sformatf("%s vec%0d err_cnt", tag, i), ec0, fault ? tbl[i].exp_err : 0);
        end
        finish_run(tag);
        check_all(tag);
    endtask

    task automatic rand_run(input int r);
        int    got;
        string tag;
        tag   = $sformatf("rand%0d", r);
        stuck = 1'($urandom_range(0, 1));
        put(3'd0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        got = 0;
        while (got < N) begin
            repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 5) == 0));
            put(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                1'b1, 1'($urandom_range(0, 7) == 0));
            got++;
        end
        finish_run(tag);
        check_all(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, want bench completion", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            tbl[i].a       = 3'(i % 8);
            tbl[i].b       = 3'(i % 8);
            tbl[i].ci      = 1'(i / 8);
            tbl[i].fmask   = (i == 7) ? 4'b1000 : 4'b0000;
            tbl[i].exp_err = (i >= 7) ? 1 : 0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk_zero("idle");
        // vec_valid in IDLE is ignored.
        put(3'd3, 3'd4, 1'b1, 4'd0, 1'b1, 1'b0);
        chk("idle valid vec_cnt", vc0, 0);
        chk("idle valid busy", busy0, 0);

        // Clean run with a start pulse mid-run; u3 sum stuck for saturation.
        stuck = 1'b1;
        dir_run("clean", 1'b0, 1'b1);
        // vec_valid in DONE is not counted.
        repeat (3) put(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, 4'b0001, 1'b1, 1'b0);
        chk("done valid u0 vec_cnt", vc0, m_acc);
        chk("done valid u0 err_cnt", ec0, sat(m_err0, 255));
        chk("done valid u2 vec_cnt", vc2, m_acc);
        chk("done valid u0 done", done0, 1);

        // Carry fault injected at index 7.
        dir_run("fault", 1'b1, 1'b0);

        // Reset mid-run after 5 vectors, then a clean run.
        stuck = 1'b0;
        put(3'd0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) put(tbl[i].a, tbl[i].b, tbl[i].ci, 4'b0010, 1'b1, 1'b0);
        chk("midrun busy before rst", busy0, 1);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst      = 1'b0;
        m_active = 1'b0;
        model_clear();
        dir_run("after_rst", 1'b0, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) rand_run(r);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_mis);
        $finish;
    end

endmodule

// File: doc/add_resp_checker.md
Name: add_resp_checker

Overview:
- Response-side checker for the WIDTH-bit ripple full adder (fa3b family). It is the receiving end of the adder stimulus interface.
- Accepts each applied vector {a, b, ci} together with the DUT's {c, s} response, possibly delayed by a fixed pipeline latency.
- Computes the golden sum, compares, and counts vectors and mismatches.
- Reports a pass/fail verdict after a programmed number of vectors. Used in simulation benches and as on-chip BIST observer.

Parameters:
- WIDTH, 3, operand width of a, b, s.
- NUM_VECTORS, 16, vectors per run before verdict.
- LAT, 0, DUT response latency in clocks (0..4); expected values delayed to match.
- CNT_W, 8, width of vector and error counters.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run (accepted in IDLE or DONE)
- vec_valid  in  1  vec_a/vec_b/vec_ci valid this cycle
- vec_a  in  WIDTH  applied operand a
- vec_b  in  WIDTH  applied operand b
- vec_ci  in  1  applied carry-in
- dut_s  in  WIDTH  DUT sum, valid LAT cycles after vec_valid
- dut_c  in  1  DUT carry-out, same timing as dut_s
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- pass  out  1  done && err_cnt==0
- vec_cnt  out  CNT_W  vectors compared this run
- err_cnt  out  CNT_W  mismatches this run, saturating
- first_err_idx  out  CNT_W  index of first mismatch (see optional feature)
- first_err_vld  out  1  a mismatch has been captured

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, delay line valid bits cleared.
- Golden model: exp = vec_a + vec_b + vec_ci, computed at WIDTH+1 bits, zero-extended. exp[WIDTH] is the carry, exp[WIDTH-1:0] the sum. No truncation before the compare.
- Delay line: LAT stages carrying {valid, exp}. With LAT=0 the compare is combinational against the current dut_s/dut_c.
- Compare: occurs when the delayed valid is 1.
  - Mismatch if {dut_c,dut_s} != exp.
  - vec_cnt increments on every compare.
  - err_cnt increments on mismatch and saturates at 2^CNT_W-1.
- FSM states and transitions:
  - IDLE: start -> RUN. Counters and delay line cleared on entry.
  - RUN: accept vec_valid until NUM_VECTORS accepted. The cycle after the last accept -> DRAIN. If LAT=0, go directly to DONE.
  - DRAIN: vec_valid ignored. After LAT cycles (all in-flight compares retired) -> DONE.
  - DONE: outputs hold. start -> RUN with counters cleared.
- start while busy: ignored.
- vec_valid in IDLE, DRAIN or DONE: ignored, not counted.
- An accept count is kept separately from vec_cnt so DRAIN length is exact.
- Reset mid-run: abandons the run; no partial verdict is kept.

Optional Feature:
- CHK_FIRST_ERR_EN defined:
  - On the first mismatch of a run, latch first_err_idx = vec_cnt value before increment, and set first_err_vld=1.
  - Both held until the next start or reset.
  - Later mismatches do not overwrite.
- Undefined: first_err_idx and first_err_vld tied to 0; no capture registers.

Decomposition:
- Package add_chk_pkg: state enum (IDLE, RUN, DRAIN, DONE), default WIDTH/CNT_W constants, LAT_MAX=4.
- Sub-module add_chk_dly: parameterized {valid, exp} shift register of depth LAT with async reset; pass-through when LAT=0.
- The FSM and counters stay in the top level.

Test Plan:
- Correct DUT model, LAT=0: start, 16 vectors (a=b in 0..7, ci=0 then 1) -> done=1, pass=1, vec_cnt=16, err_cnt=0.
- Fault injection, dut_c forced 0 on vector a=7,b=7,ci=0 (exp s=6,c=1) at index 7 -> err_cnt=1, pass=0, first_err_idx=7 when CHK_FIRST_ERR_EN is defined.
- LAT=2, responses delayed 2 clocks, vec_valid gaps of 1 cycle -> DRAIN lasts 2 cycles, then done=1, pass=1.
- start pulsed during RUN and vec_valid asserted during DONE -> neither counted; vec_cnt stays 16.
- rst asserted mid-run after 5 vectors -> all outputs 0 immediately; new start gives a clean 16-vector pass.
- CNT_W=2, dut_s stuck at 0 -> err_cnt saturates at 3, pass=0.
